// File: rtl/obstacle_pkg.sv
// Shared types, sizes and obstacle layout ROM for the obstacle scheduler.
// Each level lists its rectangles as (xpos, ypos, w, h, rgb) in slot order.
package obstacle_pkg;

  localparam int NUM_SLOTS = 4;
  localparam int LVL_W     = 3;
  localparam int IDX_W     = $clog2(NUM_SLOTS);
  localparam int CNT_W     = $clog2(NUM_SLOTS + 1);
  localparam int COORD_W   = 11;
  localparam int RGB_W     = 12;

  localparam logic [LVL_W-1:0] LVL_1 = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_2 = LVL_W'(2);
  localparam logic [LVL_W-1:0] LVL_3 = LVL_W'(3);
  localparam logic [LVL_W-1:0] LVL_4 = LVL_W'(4);

  typedef struct packed {
    logic [COORD_W-1:0] xpos;
    logic [COORD_W-1:0] ypos;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
    logic [RGB_W-1:0]   rgb;
  } desc_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_VB,
    S_LOAD,
    S_COMMIT
  } state_t;

  function automatic desc_t mk_desc(input int x, input int y, input int w, input int h,
                                    input int rgb);
    return '{xpos: COORD_W'(x), ypos: COORD_W'(y), w: COORD_W'(w), h: COORD_W'(h),
             rgb: RGB_W'(rgb)};
  endfunction

  function automatic logic [CNT_W-1:0] level_count(input logic [LVL_W-1:0] lvl);
    case (lvl)
      LVL_1:        return CNT_W'(2);
      LVL_2:        return CNT_W'(3);
      LVL_3, LVL_4: return CNT_W'(4);
      default:      return '0;
    endcase
  endfunction

  // Unused slots of a level read as an all-zero descriptor.
  function automatic desc_t level_entry(input logic [LVL_W-1:0] lvl,
                                        input logic [IDX_W-1:0] idx);
    desc_t d;
    d = '0;
    case ({lvl, idx})
      {LVL_1, IDX_W'(0)}: d = mk_desc(100, 200,  50, 100, 'hF00);
      {LVL_1, IDX_W'(1)}: d = mk_desc(400, 300,  80,  40, 'h0F0);
      {LVL_2, IDX_W'(0)}: d = mk_desc( 50,  50, 200,  20, 'h00F);
      {LVL_2, IDX_W'(1)}: d = mk_desc(300, 150,  20, 200, 'hFF0);
      {LVL_2, IDX_W'(2)}: d = mk_desc(500, 400, 100,  30, 'h0FF);
      {LVL_3, IDX_W'(0)}: d = mk_desc(  0,   0, 640,  10, 'hF0F);
      {LVL_3, IDX_W'(1)}: d = mk_desc(  0, 470, 640,  10, 'hF0F);
      {LVL_3, IDX_W'(2)}: d = mk_desc(200, 100,  30,  30, 'h888);
      {LVL_3, IDX_W'(3)}: d = mk_desc(420, 260,  60,  60, 'hFFF);
      {LVL_4, IDX_W'(0)}: d = mk_desc(120,  80,  16, 300, 'hA50);
      {LVL_4, IDX_W'(1)}: d = mk_desc(240, 160,  16, 300, 'h5A0);
      {LVL_4, IDX_W'(2)}: d = mk_desc(360,  80,  16, 300, 'h05A);
      {LVL_4, IDX_W'(3)}: d = mk_desc(480, 160,  16, 300, 'hA05);
      default:            d = '0;
    endcase
    return d;
  endfunction

  function automatic logic [NUM_SLOTS-1:0] slot_mask(input logic [CNT_W-1:0] cnt);
    logic [NUM_SLOTS-1:0] m;
    for (int i = 0; i < NUM_SLOTS; i++) m[i] = (i < int'(cnt));
    return m;
  endfunction

endpackage

// File: rtl/obstacle_rom.sv
// Combinational obstacle ROM: (level, slot) -> descriptor, level -> slot count.
module obstacle_rom
  import obstacle_pkg::*;
(
  input  logic [LVL_W-1:0] lvl,
  input  logic [IDX_W-1:0] idx,
  output desc_t            desc,
  output logic [CNT_W-1:0] count
);

  // count depends on lvl alone, so it is kept a separate path from the idx lookup.
  assign desc  = level_entry(lvl, idx);
  assign count = level_count(lvl);

endmodule

// File: rtl/obstacle_scheduler.sv
// Loads a level's obstacle descriptors into the drawing stage's shadow slots
// during vertical blanking and commits them in one cycle, so no frame is half-loaded.
module obstacle_scheduler
  import obstacle_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vblnk_in,
  input  logic [LVL_W-1:0]     lvl_req,
  input  logic                 lvl_req_valid,
  output logic                 cfg_valid,
  input  logic                 cfg_ready,
  output logic [IDX_W-1:0]     cfg_idx,
  output logic [COORD_W-1:0]   cfg_xpos,
  output logic [COORD_W-1:0]   cfg_ypos,
  output logic [COORD_W-1:0]   cfg_w,
  output logic [COORD_W-1:0]   cfg_h,
  output logic [RGB_W-1:0]     cfg_rgb,
  output logic                 cfg_commit,
  output logic [NUM_SLOTS-1:0] cfg_en,
  output logic [LVL_W-1:0]     lvl_active,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic                 vblnk_d_q;
  logic                 pend_q, pend_d;
  logic [LVL_W-1:0]     pend_lvl_q, pend_lvl_d;
  logic [LVL_W-1:0]     cur_lvl_q, cur_lvl_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 cfg_valid_q, cfg_valid_d;
  logic [IDX_W-1:0]     cfg_idx_q, cfg_idx_d;
  desc_t                cfg_desc_q, cfg_desc_d;
  logic [NUM_SLOTS-1:0] cfg_en_q, cfg_en_d;
  logic [LVL_W-1:0]     lvl_active_q, lvl_active_d;
  logic                 commit;

  logic                 vb_rise;
  logic [LVL_W-1:0]     lvl_sel;
  logic [IDX_W-1:0]     idx_sel;
  desc_t                rom_desc;
  logic [CNT_W-1:0]     rom_count;
  logic                 last_xfer;
  logic                 drop_req;

  assign vb_rise = vblnk_in & ~vblnk_d_q;

  // The ROM is addressed with the descriptor to present next cycle: slot 0 of the
  // pending level when a load starts, otherwise the slot after the one in flight.
  assign lvl_sel   = (state_q == S_WAIT_VB) ? pend_lvl_q : cur_lvl_q;
  assign idx_sel   = (state_q == S_LOAD) ? idx_q + 1'b1 : '0;
  assign last_xfer = (CNT_W'(idx_q) + CNT_W'(1)) == rom_count;
  assign drop_req  = (state_q == S_IDLE) && !pend_q && (lvl_req == lvl_active_q);

  obstacle_rom u_rom (
    .lvl   (lvl_sel),
    .idx   (idx_sel),
    .desc  (rom_desc),
    .count (rom_count)
  );

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the case infers a latch.
    state_d      = state_q;
    pend_d       = pend_q;
    pend_lvl_d   = pend_lvl_q;
    cur_lvl_d    = cur_lvl_q;
    idx_d        = idx_q;
    cfg_valid_d  = cfg_valid_q;
    cfg_idx_d    = cfg_idx_q;
    cfg_desc_d   = cfg_desc_q;
    cfg_en_d     = cfg_en_q;
    lvl_active_d = lvl_active_q;
    commit       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_q) state_d = S_WAIT_VB;
      end
      S_WAIT_VB: begin
        if (vb_rise) begin
          cur_lvl_d = pend_lvl_q;
          pend_d    = 1'b0;
          idx_d     = '0;
          if (rom_count == '0) begin
            state_d = S_COMMIT;
          end else begin
            state_d     = S_LOAD;
            cfg_valid_d = 1'b1;
            cfg_idx_d   = idx_sel;
            cfg_desc_d  = rom_desc;
          end
        end
      end
      S_LOAD: begin
        if (cfg_valid_q && cfg_ready) begin
          if (last_xfer) begin
            state_d     = S_COMMIT;
            cfg_valid_d = 1'b0;
            cfg_idx_d   = '0;
            cfg_desc_d  = '0;
          end else begin
            idx_d      = idx_sel;
            cfg_idx_d  = idx_sel;
            cfg_desc_d = rom_desc;
          end
        end
      end
      S_COMMIT: begin
        // A load that overran blanking waits here for the next blanking interval.
        if (vblnk_in) begin
          commit       = 1'b1;
          cfg_en_d     = slot_mask(rom_count);
          lvl_active_d = cur_lvl_q;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A new request overrides an older pending one, including one cleared this cycle.
    if (lvl_req_valid && !drop_req) begin
      pend_d     = 1'b1;
      pend_lvl_d = lvl_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      vblnk_d_q    <= 1'b0;
      pend_q       <= 1'b0;
      pend_lvl_q   <= '0;
      cur_lvl_q    <= '0;
      idx_q        <= '0;
      cfg_valid_q  <= 1'b0;
      cfg_idx_q    <= '0;
      cfg_desc_q   <= '0;
      cfg_en_q     <= '0;
      lvl_active_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      vblnk_d_q    <= vblnk_in;
      pend_q       <= pend_d;
      pend_lvl_q   <= pend_lvl_d;
      cur_lvl_q    <= cur_lvl_d;
      idx_q        <= idx_d;
      cfg_valid_q  <= cfg_valid_d;
      cfg_idx_q    <= cfg_idx_d;
      cfg_desc_q   <= cfg_desc_d;
      cfg_en_q     <= cfg_en_d;
      lvl_active_q <= lvl_active_d;
    end
  end

  assign cfg_valid  = cfg_valid_q;
  assign cfg_idx    = cfg_idx_q;
  assign cfg_xpos   = cfg_desc_q.xpos;
  assign cfg_ypos   = cfg_desc_q.ypos;
  assign cfg_w      = cfg_desc_q.w;
  assign cfg_h      = cfg_desc_q.h;
  assign cfg_rgb    = cfg_desc_q.rgb;
  assign cfg_commit = commit;
  assign cfg_en     = cfg_en_q;
  assign lvl_active = lvl_active_q;
  assign busy       = (state_q != S_IDLE) | pend_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Self-checking bench for obstacle_scheduler: level table plus hand-written corner
// sequences, with a descriptor scoreboard checked on every cfg handshake.
module tb_obstacle_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vblnk_in = 1'b0;
  logic [2:0]  lvl_req = '0;
  logic        lvl_req_valid = 1'b0;
  logic        cfg_valid;
  logic        cfg_ready = 1'b0;
  logic [1:0]  cfg_idx;
  logic [10:0] cfg_xpos, cfg_ypos, cfg_w, cfg_h;
  logic [11:0] cfg_rgb;
  logic        cfg_commit;
  logic [3:0]  cfg_en;
  logic [2:0]  lvl_active;
  logic        busy;

  obstacle_scheduler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .vblnk_in      (vblnk_in),
    .lvl_req       (lvl_req),
    .lvl_req_valid (lvl_req_valid),
    .cfg_valid     (cfg_valid),
    .cfg_ready     (cfg_ready),
    .cfg_idx       (cfg_idx),
    .cfg_xpos      (cfg_xpos),
    .cfg_ypos      (cfg_ypos),
    .cfg_w         (cfg_w),
    .cfg_h         (cfg_h),
    .cfg_rgb       (cfg_rgb),
    .cfg_commit    (cfg_commit),
    .cfg_en        (cfg_en),
    .lvl_active    (lvl_active),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  idx;
    logic [10:0] x;
    logic [10:0] y;
    logic [10:0] w;
    logic [10:0] h;
    logic [11:0] rgb;
  } exp_desc_t;

  typedef struct {
    int         lvl;
    int         rmode;   // 0: ready high, 1: ready toggles, 2: ready low
    logic [3:0] en;
    logic [2:0] act;
  } vec_t;

  int        n_vec = 0;
  int        n_miss = 0;
  int        ready_mode = 0;
  exp_desc_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int tb_count(input int lvl);
    case (lvl)
      1:       return 2;
      2:       return 3;
      3, 4:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic exp_desc_t tb_desc(input int lvl, input int i);
    exp_desc_t d;
    d = '0;
    d.idx = 2'(i);
    case (lvl * 10 + i)
      10: {d.x, d.y, d.w, d.h, d.rgb} = {11'd100, 11'd200, 11'd50,  11'd100, 12'hF00};
      11: {d.x, d.y, d.w, d.h, d.rgb} = {11'd400, 11'd300, 11'd80,  11'd40,  12'h0F0};
      20: {d.x, d.y, d.w, d.h, d.rgb} = {11'd50,  11'd50,  11'd200, 11'd20,  12'h00F};
      21: {d.x, d.y, d.w, d.h, d.rgb} = {11'd300, 11'd150, 11'd20,  11'd200, 12'hFF0};
      22: {d.x, d.y, d.w, d.h, d.rgb} = {11'd500, 11'd400, 11'd100, 11'd30,  12'h0FF};
      30: {d.x, d.y, d.w, d.h, d.rgb} = {11'd0,   11'd0,   11'd640, 11'd10,  12'hF0F};
      31: {d.x, d.y, d.w, d.h, d.rgb} = {11'd0,   11'd470, 11'd640, 11'd10,  12'hF0F};
      32: {d.x, d.y, d.w, d.h, d.rgb} = {11'd200, 11'd100, 11'd30,  11'd30,  12'h888};
      33: {d.x, d.y, d.w, d.h, d.rgb} = {11'd420, 11'd260, 11'd60,  11'd60,  12'hFFF};
      40: {d.x, d.y, d.w, d.h, d.rgb} = {11'd120, 11'd80,  11'd16,  11'd300, 12'hA50};
      41: {d.x, d.y, d.w, d.h, d.rgb} = {11'd240, 11'd160, 11'd16,  11'd300, 12'h5A0};
      42: {d.x, d.y, d.w, d.h, d.rgb} = {11'd360, 11'd80,  11'd16,  11'd300, 12'h05A};
      43: {d.x, d.y, d.w, d.h, d.rgb} = {11'd480, 11'd160, 11'd16,  11'd300, 12'hA05};
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [57:0] cur_word();
    return {cfg_idx, cfg_xpos, cfg_ypos, cfg_w, cfg_h, cfg_rgb};
  endfunction

  task automatic push_level(input int lvl);
    for (int i = 0; i < tb_count(lvl); i++) exp_q.push_back(tb_desc(lvl, i));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input int lvl);
    lvl_req = 3'(lvl);
    lvl_req_valid = 1'b1;
    cyc(1);
    lvl_req_valid = 1'b0;
  endtask

  task automatic wait_commit(input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (cfg_commit) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic count_commits(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (cfg_commit) seen++;
    end
  endtask

  // cfg_ready pattern generator
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       cfg_ready = 1'b1;
      1:       cfg_ready = ~cfg_ready;
      default: cfg_ready = 1'b0;
    endcase
  end

  // Handshake monitor: scoreboard pop on transfer, hold-while-stalled, zero-when-idle.
  logic        prev_stall = 1'b0;
  logic [57:0] last_word = '0;
  always @(negedge clk) begin
    exp_desc_t e;
    if (prev_stall) begin
      check("stall_hold_valid", 64'(cfg_valid), 64'd1);
      check("stall_hold_data", 64'(cur_word()), 64'(last_word));
    end
    if (cfg_valid && cfg_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_xfer: got idx %0d, expected no transfer (t=%0t)", cfg_idx, $time);
      end else begin
        e = exp_q.pop_front();
        check("xfer_desc", 64'(cur_word()), 64'(e));
      end
    end else if (!cfg_valid) begin
      check("idle_cfg_zero", 64'(cur_word()), 64'd0);
    end
    prev_stall = cfg_valid && !cfg_ready;
    last_word  = cur_word();
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[5];
    logic [3:0] en_prev;
    int         lat;
    int         seen;
    int         found;

    vecs[0] = '{lvl: 1, rmode: 0, en: 4'b0011, act: 3'd1};
    vecs[1] = '{lvl: 2, rmode: 1, en: 4'b0111, act: 3'd2};
    vecs[2] = '{lvl: 4, rmode: 0, en: 4'b1111, act: 3'd4};
    vecs[3] = '{lvl: 3, rmode: 0, en: 4'b1111, act: 3'd3};
    vecs[4] = '{lvl: 7, rmode: 0, en: 4'b0000, act: 3'd7};

    cyc(2);
    check("reset_outputs", 64'({cfg_valid, cfg_commit, cfg_en, lvl_active, busy, cur_word()}), 64'd0);
    rst_n = 1'b1;
    cyc(2);
    check("post_reset_busy", 64'(busy), 64'd0);
    en_prev = 4'b0000;

    foreach (vecs[k]) begin
      ready_mode = vecs[k].rmode;
      strobe(vecs[k].lvl);
      push_level(vecs[k].lvl);
      cyc(3);
      check("pre_vblank_busy", 64'(busy), 64'd1);
      check("pre_vblank_no_valid", 64'(cfg_valid), 64'd0);
      vblnk_in = 1'b1;
      wait_commit(60, lat);
      check("commit_seen", 64'(lat >= 0), 64'd1);
      if (vecs[k].rmode == 0) check("commit_latency", 64'(lat), 64'(tb_count(vecs[k].lvl) + 1));
      check("en_stable_in_commit", 64'(cfg_en), 64'(en_prev));
      cyc(1);
      check("commit_one_cycle", 64'(cfg_commit), 64'd0);
      check("cfg_en", 64'(cfg_en), 64'(vecs[k].en));
      check("lvl_active", 64'(lvl_active), 64'(vecs[k].act));
      check("idle_busy", 64'(busy), 64'd0);
      en_prev = vecs[k].en;
      cyc(2);
      vblnk_in = 1'b0;
      cyc(3);
    end

    // Re-request of the level already on screen is dropped.
    strobe(7);
    check("same_level_busy_now", 64'(busy), 64'd0);
    count_commits(4, seen);
    check("same_level_no_commit", 64'(seen), 64'd0);
    check("same_level_busy_later", 64'(busy), 64'd0);

    // Level 3, stalled through blanking, committed only at the next vblank rise.
    ready_mode = 2;
    strobe(3);
    push_level(3);
    cyc(2);
    vblnk_in = 1'b1;
    cyc(4);
    check("stalled_valid", 64'(cfg_valid), 64'd1);
    check("stalled_idx", 64'(cfg_idx), 64'd0);
    vblnk_in = 1'b0;
    ready_mode = 0;
    count_commits(12, seen);
    check("no_commit_outside_vblank", 64'(seen), 64'd0);
    cyc(1);
    check("overrun_load_done", 64'(cfg_valid), 64'd0);
    check("overrun_busy", 64'(busy), 64'd1);
    check("overrun_en_held", 64'(cfg_en), 64'd0);
    vblnk_in = 1'b1;
    wait_commit(5, lat);
    check("overrun_commit_at_vb_rise", 64'(lat), 64'd0);
    cyc(1);
    check("overrun_cfg_en", 64'(cfg_en), 64'hF);
    check("overrun_lvl_active", 64'(lvl_active), 64'd3);
    vblnk_in = 1'b0;
    cyc(3);

    // Back-to-back requests: the later one wins.
    strobe(1);
    strobe(2);
    push_level(2);
    cyc(2);
    vblnk_in = 1'b1;
    wait_commit(20, lat);
    check("b2b_latency", 64'(lat), 64'd4);
    cyc(1);
    check("b2b_cfg_en", 64'(cfg_en), 64'h7);
    check("b2b_lvl_active", 64'(lvl_active), 64'd2);
    vblnk_in = 1'b0;
    cyc(3);

    // Reset after the first level-1 transfer aborts the load.
    exp_q.push_back(tb_desc(1, 0));
    strobe(1);
    cyc(2);
    vblnk_in = 1'b1;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cfg_valid && cfg_ready) begin
        found = 1;
        break;
      end
    end
    check("first_xfer_seen", 64'(found), 64'd1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          64'({cfg_valid, cfg_commit, cfg_en, lvl_active, busy, cur_word()}), 64'd0);
    cyc(2);
    rst_n = 1'b1;
    count_commits(10, seen);
    check("no_commit_after_reset", 64'(seen), 64'd0);
    check("reset_cfg_en", 64'(cfg_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    vblnk_in = 1'b0;
    cyc(2);

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
